// File: rtl/or_tree_seq_reducer.sv
// Sequential OR reducer: folds a block of IN_SIZE words into one word by
// reusing a single pairwise OR layer, halving the live word count each cycle.
module or_tree_seq_reducer #(
  parameter int IN_SIZE  = 8,
  parameter int IN_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IN_SIZE*IN_WIDTH-1:0]  data_in,
  input  logic                         data_in_valid,
  output logic                         data_in_ready,
  output logic [IN_WIDTH-1:0]          data_out,
  output logic                         data_out_valid,
  input  logic                         data_out_ready,
  output logic                         busy
);
  localparam int PASSES = $clog2(IN_SIZE);
  localparam int CW     = $clog2(IN_SIZE + 1);
  localparam int CW1    = CW + 1;

  typedef enum logic [1:0] {IDLE, REDUCE, OUTPUT} state_t;

  state_t                              state_q, state_d;
  logic [IN_SIZE-1:0][IN_WIDTH-1:0]    work_q, work_d;
  logic [CW-1:0]                       cur_q, cur_d;
  logic [IN_WIDTH-1:0]                 dout_q, dout_d;
  logic                                vld_q, vld_d;

  logic [2*IN_SIZE-1:0][IN_WIDTH-1:0]  ext;
  logic [IN_SIZE-1:0][IN_WIDTH-1:0]    red;
  logic [CW1-1:0]                      half;

  // Entries at index >= cur are always zero, so an odd tail word pairs with
  // a zero and the uniform OR also covers the "carry the last word" case.
  always_comb begin
    ext                = '0;
    ext[IN_SIZE-1:0]   = work_q;
    half               = ({1'b0, cur_q} + 1'b1) >> 1;
    red                = '0;
    for (int i = 0; i < IN_SIZE; i++) begin
      if (CW1'(i) < half) red[i] = ext[2*i] | ext[2*i+1];
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cur_d   = cur_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (data_in_valid) begin
          work_d = data_in;
          cur_d  = CW'(IN_SIZE);
          if (PASSES == 0) begin
            dout_d  = data_in[IN_WIDTH-1:0];
            vld_d   = 1'b1;
            state_d = OUTPUT;
          end else begin
            state_d = REDUCE;
          end
        end
      end
      REDUCE: begin
        work_d = red;
        cur_d  = half[CW-1:0];
        if (half == CW1'(1)) begin
          dout_d  = red[0];
          vld_d   = 1'b1;
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (data_out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cur_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cur_q   <= cur_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
    end
  end

  assign data_in_ready  = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign data_out       = dout_q;
  assign data_out_valid = vld_q;
endmodule

// File: tb/tb_or_tree_seq_reducer.sv
// Directed bench for or_tree_seq_reducer at block sizes 4, 5 and 1 (8-bit words).
module tb_or_tree_seq_reducer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] din4;  logic iv4, ir4, ov4, or4, bz4;  logic [7:0] do4;
  logic [39:0] din5;  logic iv5, ir5, ov5, or5, bz5;  logic [7:0] do5;
  logic [7:0]  din1;  logic iv1, ir1, ov1, or1, bz1;  logic [7:0] do1;

  or_tree_seq_reducer #(.IN_SIZE(4), .IN_WIDTH(8)) u4 (
    .clk(clk), .rst(rst), .data_in(din4), .data_in_valid(iv4), .data_in_ready(ir4),
    .data_out(do4), .data_out_valid(ov4), .data_out_ready(or4), .busy(bz4));
  or_tree_seq_reducer #(.IN_SIZE(5), .IN_WIDTH(8)) u5 (
    .clk(clk), .rst(rst), .data_in(din5), .data_in_valid(iv5), .data_in_ready(ir5),
    .data_out(do5), .data_out_valid(ov5), .data_out_ready(or5), .busy(bz5));
  or_tree_seq_reducer #(.IN_SIZE(1), .IN_WIDTH(8)) u1 (
    .clk(clk), .rst(rst), .data_in(din1), .data_in_valid(iv1), .data_in_ready(ir1),
    .data_out(do1), .data_out_valid(ov1), .data_out_ready(or1), .busy(bz1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  logic [31:0] blk [3];
  logic [7:0]  bexp [3];

  initial begin
    din4 = '0; iv4 = 0; or4 = 1;
    din5 = '0; iv5 = 0; or5 = 1;
    din1 = '0; iv1 = 0; or1 = 1;
    #12;
    chk("rst_ready4", {31'd0, ir4}, 1);
    chk("rst_valid4", {31'd0, ov4}, 0);
    chk("rst_busy4",  {31'd0, bz4}, 0);
    chk("rst_dout5",  {24'd0, do5}, 0);
    rst = 1'b1;
    tick();

    // basic IN_SIZE=4, ready high
    din4 = {8'h80, 8'h04, 8'h02, 8'h01}; iv4 = 1;
    tick(); iv4 = 0;
    chk("t1_busy",   {31'd0, bz4}, 1);
    chk("t1_rdy0",   {31'd0, ir4}, 0);
    chk("t1_v_e0",   {31'd0, ov4}, 0);
    tick();
    chk("t1_v_e1",   {31'd0, ov4}, 0);
    tick();
    chk("t1_v_e2",   {31'd0, ov4}, 1);
    chk("t1_dout",   {24'd0, do4}, 32'h87);
    tick();
    chk("t1_v_off",  {31'd0, ov4}, 0);
    chk("t1_rdy1",   {31'd0, ir4}, 1);

    // backpressure
    or4 = 0; iv4 = 1;
    tick(); iv4 = 0;
    tick(); tick();
    for (int c = 0; c < 4; c++) begin
      chk("bp_valid", {31'd0, ov4}, 1);
      chk("bp_dout",  {24'd0, do4}, 32'h87);
      chk("bp_rdy",   {31'd0, ir4}, 0);
      tick();
    end
    or4 = 1;
    tick();
    chk("bp_done_v", {31'd0, ov4}, 0);
    chk("bp_idle",   {31'd0, ir4}, 1);

    // IN_SIZE=5: three passes
    din5 = {8'h10, 8'h08, 8'h04, 8'h02, 8'h01}; iv5 = 1;
    tick(); iv5 = 0;
    tick(); tick();
    chk("t5_v_e2", {31'd0, ov5}, 0);
    tick();
    chk("t5_v_e3", {31'd0, ov5}, 1);
    chk("t5_dout", {24'd0, do5}, 32'h1F);
    tick();
    din5 = '0; iv5 = 1;
    tick(); iv5 = 0;
    tick(); tick(); tick();
    chk("t5z_v",    {31'd0, ov5}, 1);
    chk("t5z_dout", {24'd0, do5}, 32'h00);
    tick();

    // reset during a reduce pass
    din4 = 32'hFFFF_FFFF; iv4 = 1;
    tick(); iv4 = 0;
    rst = 1'b0; #1;
    chk("rr_valid", {31'd0, ov4}, 0);
    chk("rr_busy",  {31'd0, bz4}, 0);
    chk("rr_dout",  {24'd0, do4}, 0);
    tick();
    rst = 1'b1;
    tick();
    din4 = {8'h00, 8'h00, 8'h00, 8'h10}; iv4 = 1;
    tick(); iv4 = 0;
    tick(); tick();
    chk("rr_new_v",    {31'd0, ov4}, 1);
    chk("rr_new_dout", {24'd0, do4}, 32'h10);
    tick();

    // IN_SIZE=1, input changes while busy
    din1 = 8'hA5; iv1 = 1; or1 = 0;
    tick(); iv1 = 0; din1 = 8'hFF;
    chk("s1_v",    {31'd0, ov1}, 1);
    chk("s1_dout", {24'd0, do1}, 32'hA5);
    tick();
    chk("s1_hold", {24'd0, do1}, 32'hA5);
    or1 = 1;
    tick();
    chk("s1_done", {31'd0, ov1}, 0);

    // back-to-back with valid held high
    for (int b = 0; b < 3; b++) begin
      blk[b]  = $urandom;
      bexp[b] = blk[b][7:0] | blk[b][15:8] | blk[b][23:16] | blk[b][31:24];
    end
    begin
      int k = 0, n = 0;
      logic acc;
      for (int c = 0; c < 60 && n < 3; c++) begin
        if (ov4) begin
          chk("b2b_dout", {24'd0, do4}, {24'd0, bexp[n]});
          n++;
        end
        iv4  = (k < 3);
        din4 = (k < 3) ? blk[k] : '0;
        acc  = iv4 && ir4;
        if (acc) chk("b2b_idle", {31'd0, bz4}, 0);
        tick();
        if (acc) k++;
      end
      iv4 = 0;
      chk("b2b_acc", k, 3);
      chk("b2b_out", n, 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
